// File: rtl/rv64_alu_pkg.sv
// Shared definitions for the RV64I integer ALU.
// Holds the datapath width and the 16 legal 5-bit control codes.
// Control code layout: bit4 = branch class, bit3 = alternate op (SUB/SRA),
// bits[2:0] = funct3.
package rv64_alu_pkg;

    localparam int XLEN = 64;

    // Arithmetic / logic codes (bit4 = 0)
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;

    // Branch-compare codes (bit4 = 1, bit3 = 0)
    localparam logic [4:0] BR_EQ    = 5'b10000;
    localparam logic [4:0] BR_NE    = 5'b10001;
    localparam logic [4:0] BR_LT    = 5'b10100;
    localparam logic [4:0] BR_GE    = 5'b10101;
    localparam logic [4:0] BR_LTU   = 5'b10110;
    localparam logic [4:0] BR_GEU   = 5'b10111;

endpackage

// File: rtl/rv64_alu_core.sv
// Combinational core of the RV64I ALU.
// Decodes the control code and produces the next result, branch flag and
// legality flag. Any code not in the legal set yields zero result, no branch
// and an invalid flag.
// Ports:
//   i_a, i_b        operands (XLEN bits)
//   i_control       5-bit operation select
//   o_next_out      result to be registered
//   o_next_branch   branch condition to be registered
//   o_next_valid    1 when i_control is a legal code
module rv64_alu_core
    import rv64_alu_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [4:0]      i_control,
    output logic [XLEN-1:0] o_next_out,
    output logic            o_next_branch,
    output logic            o_next_valid
);

    // Only the low six bits of b select the shift distance.
    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_sra;
    logic            w_eq;
    logic            w_lt_s;
    logic            w_lt_u;

    assign w_shamt = i_b[5:0];
    assign w_sra   = $signed(i_a) >>> w_shamt;
    assign w_eq    = (i_a == i_b);
    assign w_lt_s  = ($signed(i_a) < $signed(i_b));
    assign w_lt_u  = (i_a < i_b);

    // Operation decode: result, branch condition and legality.
    always_comb begin
        o_next_out    = {XLEN{1'b0}};
        o_next_branch = 1'b0;
        o_next_valid  = 1'b1;
        case (i_control)
            ALU_ADD:  o_next_out = i_a + i_b;
            ALU_SUB:  o_next_out = i_a - i_b;
            ALU_SLL:  o_next_out = i_a << w_shamt;
            ALU_SRL:  o_next_out = i_a >> w_shamt;
            ALU_SRA:  o_next_out = w_sra;
            ALU_SLT:  o_next_out = {{(XLEN-1){1'b0}}, w_lt_s};
            ALU_SLTU: o_next_out = {{(XLEN-1){1'b0}}, w_lt_u};
            ALU_XOR:  o_next_out = i_a ^ i_b;
            ALU_OR:   o_next_out = i_a | i_b;
            ALU_AND:  o_next_out = i_a & i_b;
            BR_EQ:    o_next_branch = w_eq;
            BR_NE:    o_next_branch = ~w_eq;
            BR_LT:    o_next_branch = w_lt_s;
            BR_GE:    o_next_branch = ~w_lt_s;
            BR_LTU:   o_next_branch = w_lt_u;
            BR_GEU:   o_next_branch = ~w_lt_u;
            default:  o_next_valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv64_alu.sv
// RV64I integer ALU, top level.
// Registers the core's result, branch flag and legality flag with one cycle
// of latency. Synchronous active-high reset has priority over any operation.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   a, b       operands (64 bits)
//   control    5-bit operation select
//   out        registered result
//   branchAlu  registered branch-taken flag
//   valid      registered: sampled control was a legal code
module rv64_alu
    import rv64_alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      control,
    output logic [XLEN-1:0] out,
    output logic            branchAlu,
    output logic            valid
);

    logic [XLEN-1:0] w_next_out;
    logic            w_next_branch;
    logic            w_next_valid;

    logic [XLEN-1:0] r_out;
    logic            r_branch;
    logic            r_valid;

    rv64_alu_core u_core (
        .i_a           (a),
        .i_b           (b),
        .i_control     (control),
        .o_next_out    (w_next_out),
        .o_next_branch (w_next_branch),
        .o_next_valid  (w_next_valid)
    );

    // Output registers; a reset cycle discards that cycle's operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out    <= {XLEN{1'b0}};
            r_branch <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_out    <= w_next_out;
            r_branch <= w_next_branch;
            r_valid  <= w_next_valid;
        end
    end

    assign out       = r_out;
    assign branchAlu = r_branch;
    assign valid     = r_valid;

endmodule

// File: tb/tb_rv64_alu.sv
// Self-checking bench for rv64_alu: directed steps from the test plan plus
// randomized operations compared against an arithmetic reference model.
module tb_rv64_alu;

    logic        clk;
    logic        rst;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  control;
    logic [63:0] out;
    logic        branchAlu;
    logic        valid;

    int n_total;
    int n_pass;

    rv64_alu dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .control   (control),
        .out       (out),
        .branchAlu (branchAlu),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: RV64I semantics written with plain arithmetic.
    // Signed ordering is obtained by biasing both operands by 2^63 and
    // comparing unsigned.
    function automatic void model(input logic [4:0] c, input logic [63:0] x,
                                  input logic [63:0] y, output logic [63:0] o,
                                  output logic br, output logic v);
        int          sh;
        logic [63:0] bias;
        logic [63:0] fill;
        logic        slt;
        logic        sltu;
        sh   = int'(y % 64'd64);
        bias = 64'h8000_0000_0000_0000;
        slt  = ((x ^ bias) < (y ^ bias));
        sltu = (x < y);
        fill = x[63] ? ~(64'hFFFF_FFFF_FFFF_FFFF >> sh) : 64'd0;
        o  = 64'd0;
        br = 1'b0;
        v  = 1'b1;
        case (c)
            5'b00000: o = x + y;
            5'b01000: o = x + (~y) + 64'd1;
            5'b00001: o = x * (64'd1 << sh);
            5'b00101: o = x / (64'd1 << sh);
            5'b01101: o = (x / (64'd1 << sh)) | fill;
            5'b00010: o = slt ? 64'd1 : 64'd0;
            5'b00011: o = sltu ? 64'd1 : 64'd0;
            5'b00100: o = x ^ y;
            5'b00110: o = x | y;
            5'b00111: o = x & y;
            5'b10000: br = (x == y);
            5'b10001: br = (x != y);
            5'b10100: br = slt;
            5'b10101: br = !slt;
            5'b10110: br = sltu;
            5'b10111: br = !sltu;
            default:  v = 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%016h expected=0x%016h", tag, obs, exp);
    endtask

    // Drive one operation, then sample 1 time unit after the active edge.
    task automatic step(input logic r, input logic [4:0] c, input logic [63:0] x, input logic [63:0] y);
        rst = r; control = c; a = x; b = y;
        @(posedge clk);
        #1;
    endtask

    task automatic check3(input string tag, input logic [63:0] eo, input logic eb, input logic ev);
        check({tag, ".out"}, out, eo);
        check({tag, ".br"}, {63'd0, branchAlu}, {63'd0, eb});
        check({tag, ".valid"}, {63'd0, valid}, {63'd0, ev});
    endtask

    task automatic op(input string tag, input logic [4:0] c, input logic [63:0] x,
                      input logic [63:0] y, input logic [63:0] eo, input logic eb, input logic ev);
        step(1'b0, c, x, y);
        check3(tag, eo, eb, ev);
    endtask

    initial begin
        logic [63:0] mo;
        logic        mb;
        logic        mv;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [4:0]  rc;
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1; a = 64'd5; b = 64'd3; control = 5'b00000;

        // Reset held two cycles with an ADD pending
        step(1'b1, 5'b00000, 64'd5, 64'd3);
        check3("rst1", 64'd0, 1'b0, 1'b0);
        step(1'b1, 5'b00000, 64'd5, 64'd3);
        check3("rst2", 64'd0, 1'b0, 1'b0);
        op("rel_add", 5'b00000, 64'd5, 64'd3, 64'd8, 1'b0, 1'b1);

        // Arithmetic / logic
        op("sub", 5'b01000, 64'd5, 64'd3, 64'd2, 1'b0, 1'b1);
        op("xor", 5'b00100, 64'd5, 64'd3, 64'd6, 1'b0, 1'b1);
        op("or",  5'b00110, 64'd5, 64'd3, 64'd7, 1'b0, 1'b1);
        op("and", 5'b00111, 64'd5, 64'd3, 64'd1, 1'b0, 1'b1);
        op("sub_neg", 5'b01000, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);

        // Shifts
        op("sll", 5'b00001, 64'hF0, 64'd4, 64'hF00, 1'b0, 1'b1);
        op("srl", 5'b00101, 64'hF0, 64'd4, 64'hF, 1'b0, 1'b1);
        op("sra_pos", 5'b01101, 64'hF0, 64'd4, 64'hF, 1'b0, 1'b1);
        op("sra_neg", 5'b01101, 64'h8000_0000_0000_00F0, 64'd4, 64'hF800_0000_0000_000F, 1'b0, 1'b1);
        op("srl_neg", 5'b00101, 64'h8000_0000_0000_00F0, 64'd4, 64'h0800_0000_0000_000F, 1'b0, 1'b1);
        op("sll_hib", 5'b00001, 64'hF0, 64'h104, 64'hF00, 1'b0, 1'b1);
        op("sra_hib", 5'b01101, 64'h8000_0000_0000_00F0, 64'h104, 64'hF800_0000_0000_000F, 1'b0, 1'b1);
        op("sll_0", 5'b00001, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1);
        op("sra_63", 5'b01101, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        op("srl_63", 5'b00101, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0, 1'b1);

        // Compares
        op("slt_58", 5'b00010, 64'd5, 64'd8, 64'd1, 1'b0, 1'b1);
        op("sltu_58", 5'b00011, 64'd5, 64'd8, 64'd1, 1'b0, 1'b1);
        op("slt_m1", 5'b00010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b1);
        op("sltu_m1", 5'b00011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b1);
        op("blt_m1", 5'b10100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1);
        op("bltu_m1", 5'b10110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b1);
        op("slt_min", 5'b00010, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
        op("bge_min", 5'b10101, 64'd0, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b1);

        // Branches with equal operands
        op("beq", 5'b10000, 64'd5, 64'd5, 64'd0, 1'b1, 1'b1);
        op("bne", 5'b10001, 64'd5, 64'd5, 64'd0, 1'b0, 1'b1);
        op("blt", 5'b10100, 64'd5, 64'd5, 64'd0, 1'b0, 1'b1);
        op("bge", 5'b10101, 64'd5, 64'd5, 64'd0, 1'b1, 1'b1);
        op("bltu", 5'b10110, 64'd5, 64'd5, 64'd0, 1'b0, 1'b1);
        op("bgeu", 5'b10111, 64'd5, 64'd5, 64'd0, 1'b1, 1'b1);

        // Illegal codes, then recovery
        op("ill_01001", 5'b01001, 64'd5, 64'd3, 64'd0, 1'b0, 1'b0);
        op("ill_10010", 5'b10010, 64'd5, 64'd5, 64'd0, 1'b0, 1'b0);
        op("ill_11111", 5'b11111, 64'd5, 64'd5, 64'd0, 1'b0, 1'b0);
        op("ill_11000", 5'b11000, 64'd5, 64'd5, 64'd0, 1'b0, 1'b0);
        op("after_ill", 5'b00000, 64'd5, 64'd3, 64'd8, 1'b0, 1'b1);

        // Reset between two ops clears outputs for that cycle only
        op("pre_rst", 5'b10000, 64'd7, 64'd7, 64'd0, 1'b1, 1'b1);
        step(1'b1, 5'b00110, 64'd5, 64'd3);
        check3("mid_rst", 64'd0, 1'b0, 1'b0);
        op("post_rst", 5'b01000, 64'd5, 64'd3, 64'd2, 1'b0, 1'b1);

        // Randomized operations against the reference model
        for (int i = 0; i < 400; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: ra = {ra[63], 63'd0};
                default: ;
            endcase
            step(1'b0, rc, ra, rb);
            model(rc, ra, rb, mo, mb, mv);
            check($sformatf("rnd%0d.c%05b.out", i, rc), out, mo);
            check($sformatf("rnd%0d.c%05b.br", i, rc), {63'd0, branchAlu}, {63'd0, mb});
            check($sformatf("rnd%0d.c%05b.valid", i, rc), {63'd0, valid}, {63'd0, mv});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rv64_alu.md
Name: rv64_alu

Overview:
- 64-bit integer ALU for the RV64I datapath; executes arithmetic, logical, shift, set-less-than and branch-compare operations selected by a 5-bit control code.
- Operands come from register file / immediate mux; results are registered with one-cycle latency.
- Feeds writeback (out) and branch resolution (branchAlu).

Parameters:
- XLEN, 64, operand/result width. Shift amount uses b[5:0] at XLEN=64.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- a  in  64  operand A (rs1)
- b  in  64  operand B (rs2 or immediate)
- control  in  5  operation select: bit4=branch class, bit3=alt (SUB/SRA), bits[2:0]=funct3
- out  out  64  registered result
- branchAlu  out  1  registered branch-taken flag
- valid  out  1  registered: previous-cycle control was a legal code

Behaviour:
- Reset: on a rising clk with rst=1, out=0, branchAlu=0, valid=0. Reset has priority over every operation. A reset asserted mid-stream discards that cycle's operation.
- Latency: a, b and control are sampled each rising edge. Outputs reflect that sample from the edge onward and hold until the next edge.
- There is no handshake; every cycle is an independent operation.
- Arithmetic/logic codes (bit4=0):
  - 00000 ADD: a+b, mod 2^64
  - 01000 SUB: a-b, mod 2^64
  - 00001 SLL: a << b[5:0]
  - 00101 SRL: logical right shift by b[5:0]
  - 01101 SRA: arithmetic right shift by b[5:0], sign-filled from a[63]
  - 00010 SLT: signed a<b gives 1, else 0, zero-extended
  - 00011 SLTU: unsigned compare, same encoding as SLT
  - 00100 XOR, 00110 OR, 00111 AND: bitwise
  - For these codes branchAlu=0.
- Branch codes (bit4=1, bit3=0). out=0; branchAlu=condition:
  - 10000 BEQ: a==b
  - 10001 BNE: a!=b
  - 10100 BLT: signed a<b
  - 10101 BGE: signed a>=b
  - 10110 BLTU: unsigned a<b
  - 10111 BGEU: unsigned a>=b
- Illegal codes register out=0, branchAlu=0, valid=0. The illegal set is:
  - 01001, 01010, 01011, 01100, 01110, 01111
  - 10010, 10011
  - every 11xxx
- Legal codes register valid=1.
- Shift boundaries: b[63:6] are ignored. A shift of 0 returns a unchanged. A shift of 63 is legal; SRA by 63 gives all a[63].
- Compare boundaries:
  - Signed compares treat 0x8000_0000_0000_0000 as the minimum value.
  - Equal operands: BLT/BLTU=0, BGE/BGEU=1.

Decomposition:
- Shared package rv64_alu_pkg: XLEN constant, plus named localparams for all 16 legal control codes (ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU). The control decoder shares these.
- One sub-module, rv64_alu_core: purely combinational. It computes next_out, next_branch and next_valid from a, b and control.
- The top level rv64_alu holds only the output registers and reset.

Test Plan:
- Reset: hold rst=1 with a=5, b=3, control=00000 for 2 cycles. Required: out=0, branchAlu=0, valid=0. Release rst; one edge later out=8, valid=1.
- Arithmetic/logic with a=5, b=3, one code per cycle, checking one edge later. Required: valid=1 and branchAlu=0 throughout.
  - ADD -> 8
  - SUB -> 2
  - XOR -> 6
  - OR -> 7
  - AND -> 1
  - a=3, b=5, SUB -> 0xFFFF_FFFF_FFFF_FFFE
- Shifts with b=4:
  - a=0xF0: SLL -> 0xF00
  - a=0xF0: SRL -> 0xF
  - a=0xF0: SRA -> 0xF
  - a=0x8000_0000_0000_00F0: SRA -> 0xF800_0000_0000_000F
  - a=0x8000_0000_0000_00F0: SRL -> 0x0800_0000_0000_000F
  - b=0x104 (b[5:0]=4) gives results identical to b=4.
- Compares:
  - a=5, b=8: SLT=1, SLTU=1
  - a=-1, b=1: SLT=1, SLTU=0, BLT branchAlu=1, BLTU branchAlu=0
- Branches with a=b=5: BEQ=1, BNE=0, BLT=0, BGE=1, BLTU=0, BGEU=1. Required: out=0 and valid=1 for each.
- Illegal codes: 01001, 10010 and 11111 each give out=0, branchAlu=0, valid=0. The following legal ADD restores valid=1. Asserting rst in the cycle between two ops clears all outputs for exactly that cycle.
